// File: rtl/stack_pointer_unit_pkg.sv
// ============================================================================
// Module      : stack_pointer_unit_pkg
// Description : Stack-op encodings and default stack placement shared with
//               the memory map.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stack_pointer_unit_pkg;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   localparam int unsigned DEF_ADDR_W  = 16;
   localparam int unsigned DEF_MS_BASE = 32'h0000_1000;
   localparam int unsigned DEF_MS_SIZE = 256;
   localparam int unsigned DEF_RS_BASE = 32'h0000_1800;
   localparam int unsigned DEF_RS_SIZE = 64;

   // Occupancy must be able to hold SIZE itself, hence SIZE+1 states.
   function automatic int unsigned depth_width(input int unsigned size);
      return $clog2(size + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/stack_pointer_unit_if.sv
// ============================================================================
// Module      : stack_pointer_unit_if
// Description : Strobe and address bundle between control unit, memory stage
//               and the stack pointer unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stack_pointer_unit_if
   import stack_pointer_unit_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned MS_SIZE = DEF_MS_SIZE,
   parameter int unsigned RS_SIZE = DEF_RS_SIZE
);

   localparam int unsigned MS_DW = depth_width(MS_SIZE);
   localparam int unsigned RS_DW = depth_width(RS_SIZE);

   logic              MSPWrite;
   logic              MSPop;
   logic              RSPWrite;
   logic              RSPop;
   logic              ErrClr;

   logic [ADDR_W-1:0] MSTop;
   logic [ADDR_W-1:0] MSNext;
   logic [ADDR_W-1:0] MSPushAddr;
   logic [ADDR_W-1:0] RSTop;
   logic [ADDR_W-1:0] RSPushAddr;
   logic [MS_DW-1:0]  MSDepth;
   logic [RS_DW-1:0]  RSDepth;
   logic              MSEmpty;
   logic              MSFull;
   logic              RSEmpty;
   logic              RSFull;
   logic              MSOverflow;
   logic              MSUnderflow;
   logic              RSOverflow;
   logic              RSUnderflow;
   logic              StackFault;

   modport master (
      output MSPWrite, MSPop, RSPWrite, RSPop, ErrClr,
      input  MSTop, MSNext, MSPushAddr, RSTop, RSPushAddr,
      input  MSDepth, RSDepth, MSEmpty, MSFull, RSEmpty, RSFull,
      input  MSOverflow, MSUnderflow, RSOverflow, RSUnderflow, StackFault
   );

   modport slave (
      input  MSPWrite, MSPop, RSPWrite, RSPop, ErrClr,
      output MSTop, MSNext, MSPushAddr, RSTop, RSPushAddr,
      output MSDepth, RSDepth, MSEmpty, MSFull, RSEmpty, RSFull,
      output MSOverflow, MSUnderflow, RSOverflow, RSUnderflow, StackFault
   );

endinterface

`default_nettype wire

// File: rtl/stack_pointer_unit_stack_ptr.sv
// ============================================================================
// Module      : stack_ptr
// Description : One downward-growing stack: pointer, occupancy counter and
//               sticky overflow/underflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_ptr
   import stack_pointer_unit_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned BASE    = DEF_MS_BASE,
   parameter int unsigned SIZE    = DEF_MS_SIZE,
   parameter int unsigned DEPTH_W = depth_width(SIZE)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               wr_i,
   input  logic               pop_i,
   input  logic               err_clr_i,
   output logic [ADDR_W-1:0]  top_o,
   output logic [ADDR_W-1:0]  push_addr_o,
   output logic [DEPTH_W-1:0] depth_o,
   output logic               empty_o,
   output logic               full_o,
   output logic               ovf_o,
   output logic               udf_o
);

   localparam logic [ADDR_W-1:0]  c_base = ADDR_W'(BASE);
   localparam logic [DEPTH_W-1:0] c_size = DEPTH_W'(SIZE);

   logic [ADDR_W-1:0]  sp_q,    sp_d;
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic               ovf_q,   ovf_d;
   logic               udf_q,   udf_d;
   logic               w_empty;
   logic               w_full;

   assign w_empty = (depth_q == '0);
   assign w_full  = (depth_q == c_size);

   // Clear is applied first so a fault in the same cycle re-sets its flag.
   always_comb begin
      sp_d    = sp_q;
      depth_d = depth_q;
      ovf_d   = ovf_q & ~err_clr_i;
      udf_d   = udf_q & ~err_clr_i;
      if (wr_i) begin
         if (pop_i == OP_POP) begin
            if (w_empty) begin
               udf_d = 1'b1;
            end else begin
               sp_d    = sp_q + ADDR_W'(1);
               depth_d = depth_q - DEPTH_W'(1);
            end
         end else begin
            if (w_full) begin
               ovf_d = 1'b1;
            end else begin
               sp_d    = sp_q - ADDR_W'(1);
               depth_d = depth_q + DEPTH_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sp_q    <= c_base;
         depth_q <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         sp_q    <= sp_d;
         depth_q <= depth_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign top_o       = sp_q;
   assign push_addr_o = sp_q - ADDR_W'(1);
   assign depth_o     = depth_q;
   assign empty_o     = w_empty;
   assign full_o      = w_full;
   assign ovf_o       = ovf_q;
   assign udf_o       = udf_q;

endmodule

`default_nettype wire

// File: rtl/stack_pointer_unit.sv
// ============================================================================
// Module      : stack_pointer_unit
// Description : Main-stack and return-stack pointer engines for the stack
//               CPU, with combined fault indication.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stack_pointer_unit
   import stack_pointer_unit_pkg::*;
#(
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned MS_BASE = DEF_MS_BASE,
   parameter int unsigned MS_SIZE = DEF_MS_SIZE,
   parameter int unsigned RS_BASE = DEF_RS_BASE,
   parameter int unsigned RS_SIZE = DEF_RS_SIZE
) (
   input  logic                CLK,
   input  logic                CtrlRst,
   stack_pointer_unit_if.slave bus
);

   stack_ptr #(
      .ADDR_W (ADDR_W),
      .BASE   (MS_BASE),
      .SIZE   (MS_SIZE)
   ) u_ms (
      .clk_i       (CLK),
      .rst_i       (CtrlRst),
      .wr_i        (bus.MSPWrite),
      .pop_i       (bus.MSPop),
      .err_clr_i   (bus.ErrClr),
      .top_o       (bus.MSTop),
      .push_addr_o (bus.MSPushAddr),
      .depth_o     (bus.MSDepth),
      .empty_o     (bus.MSEmpty),
      .full_o      (bus.MSFull),
      .ovf_o       (bus.MSOverflow),
      .udf_o       (bus.MSUnderflow)
   );

   stack_ptr #(
      .ADDR_W (ADDR_W),
      .BASE   (RS_BASE),
      .SIZE   (RS_SIZE)
   ) u_rs (
      .clk_i       (CLK),
      .rst_i       (CtrlRst),
      .wr_i        (bus.RSPWrite),
      .pop_i       (bus.RSPop),
      .err_clr_i   (bus.ErrClr),
      .top_o       (bus.RSTop),
      .push_addr_o (bus.RSPushAddr),
      .depth_o     (bus.RSDepth),
      .empty_o     (bus.RSEmpty),
      .full_o      (bus.RSFull),
      .ovf_o       (bus.RSOverflow),
      .udf_o       (bus.RSUnderflow)
   );

   // Only the main stack exposes a second-element address.
   assign bus.MSNext     = bus.MSTop + ADDR_W'(1);
   assign bus.StackFault = bus.MSOverflow | bus.MSUnderflow |
                           bus.RSOverflow | bus.RSUnderflow;

endmodule

`default_nettype wire

// File: tb/tb_stack_pointer_unit.sv
// ============================================================================
// Module      : tb_stack_pointer_unit
// Description : Scoreboard bench for stack_pointer_unit with small stacks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stack_pointer_unit;
   import stack_pointer_unit_pkg::*;

   localparam int unsigned AW  = 16;
   localparam int unsigned MSS = 4;
   localparam int unsigned RSS = 2;
   localparam logic [15:0] MSB = 16'h1000;
   localparam logic [15:0] RSB = 16'h1800;

   typedef struct packed {
      logic [15:0] ms_top;
      logic [15:0] ms_next;
      logic [15:0] ms_push;
      logic [15:0] rs_top;
      logic [15:0] rs_push;
      logic [2:0]  ms_depth;
      logic [1:0]  rs_depth;
      logic        ms_empty;
      logic        ms_full;
      logic        rs_empty;
      logic        rs_full;
      logic        ms_ovf;
      logic        ms_udf;
      logic        rs_ovf;
      logic        rs_udf;
      logic        fault;
   } snap_t;

   logic CLK = 1'b0;
   logic CtrlRst;
   always #5 CLK = ~CLK;

   stack_pointer_unit_if #(.ADDR_W(AW), .MS_SIZE(MSS), .RS_SIZE(RSS)) bus ();

   stack_pointer_unit #(
      .ADDR_W  (AW),
      .MS_BASE (32'h0000_1000),
      .MS_SIZE (MSS),
      .RS_BASE (32'h0000_1800),
      .RS_SIZE (RSS)
   ) dut (
      .CLK     (CLK),
      .CtrlRst (CtrlRst),
      .bus     (bus)
   );

   int    total = 0;
   int    bad   = 0;
   snap_t sb[$];
   snap_t got, exp;

   logic [15:0] m_ms_sp, m_rs_sp;
   int          m_msd, m_rsd;
   logic        m_mso, m_msu, m_rso, m_rsu;

   function automatic snap_t sample();
      snap_t s;
      s.ms_top   = bus.MSTop;
      s.ms_next  = bus.MSNext;
      s.ms_push  = bus.MSPushAddr;
      s.rs_top   = bus.RSTop;
      s.rs_push  = bus.RSPushAddr;
      s.ms_depth = bus.MSDepth;
      s.rs_depth = bus.RSDepth;
      s.ms_empty = bus.MSEmpty;
      s.ms_full  = bus.MSFull;
      s.rs_empty = bus.RSEmpty;
      s.rs_full  = bus.RSFull;
      s.ms_ovf   = bus.MSOverflow;
      s.ms_udf   = bus.MSUnderflow;
      s.rs_ovf   = bus.RSOverflow;
      s.rs_udf   = bus.RSUnderflow;
      s.fault    = bus.StackFault;
      return s;
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      s.ms_top   = m_ms_sp;
      s.ms_next  = m_ms_sp + 16'd1;
      s.ms_push  = m_ms_sp - 16'd1;
      s.rs_top   = m_rs_sp;
      s.rs_push  = m_rs_sp - 16'd1;
      s.ms_depth = 3'(m_msd);
      s.rs_depth = 2'(m_rsd);
      s.ms_empty = (m_msd == 0);
      s.ms_full  = (m_msd == int'(MSS));
      s.rs_empty = (m_rsd == 0);
      s.rs_full  = (m_rsd == int'(RSS));
      s.ms_ovf   = m_mso;
      s.ms_udf   = m_msu;
      s.rs_ovf   = m_rso;
      s.rs_udf   = m_rsu;
      s.fault    = m_mso | m_msu | m_rso | m_rsu;
      return s;
   endfunction

   task automatic model_reset();
      m_ms_sp = MSB; m_rs_sp = RSB;
      m_msd = 0; m_rsd = 0;
      m_mso = 0; m_msu = 0; m_rso = 0; m_rsu = 0;
   endtask

   task automatic do_reset();
      CtrlRst = 1'b1;
      #2;
      CtrlRst = 1'b0;
      model_reset();
   endtask

   // Drive one cycle of strobes, predict the post-edge state, wait past the edge.
   task automatic drive(input logic msw, input logic msp, input logic rsw,
                        input logic rsp, input logic clr);
      bus.MSPWrite = msw; bus.MSPop = msp;
      bus.RSPWrite = rsw; bus.RSPop = rsp;
      bus.ErrClr   = clr;
      if (clr) begin m_mso = 0; m_msu = 0; m_rso = 0; m_rsu = 0; end
      if (msw) begin
         if (msp) begin
            if (m_msd == 0) m_msu = 1;
            else begin m_ms_sp = m_ms_sp + 16'd1; m_msd = m_msd - 1; end
         end else begin
            if (m_msd == int'(MSS)) m_mso = 1;
            else begin m_ms_sp = m_ms_sp - 16'd1; m_msd = m_msd + 1; end
         end
      end
      if (rsw) begin
         if (rsp) begin
            if (m_rsd == 0) m_rsu = 1;
            else begin m_rs_sp = m_rs_sp + 16'd1; m_rsd = m_rsd - 1; end
         end else begin
            if (m_rsd == int'(RSS)) m_rso = 1;
            else begin m_rs_sp = m_rs_sp - 16'd1; m_rsd = m_rsd + 1; end
         end
      end
      sb.push_back(model_snap());
      @(posedge CLK);
      #1;
      bus.MSPWrite = 1'b0; bus.MSPop = 1'b0;
      bus.RSPWrite = 1'b0; bus.RSPop = 1'b0;
      bus.ErrClr   = 1'b0;
   endtask

   task automatic test_reset();
      exp = model_snap(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL reset_snap got=%h exp=%h", got, exp); end
      total++;
      if (bus.MSTop !== 16'h1000) begin bad++; $display("FAIL reset_mstop got=%h exp=1000", bus.MSTop); end
      total++;
      if (bus.MSPushAddr !== 16'h0FFF) begin bad++; $display("FAIL reset_mspush got=%h exp=0fff", bus.MSPushAddr); end
      total++;
      if (bus.MSNext !== 16'h1001) begin bad++; $display("FAIL reset_msnext got=%h exp=1001", bus.MSNext); end
      total++;
      if (bus.RSTop !== 16'h1800) begin bad++; $display("FAIL reset_rstop got=%h exp=1800", bus.RSTop); end
      total++;
      if (bus.MSEmpty !== 1'b1 || bus.MSDepth !== 3'd0 || bus.StackFault !== 1'b0) begin
         bad++; $display("FAIL reset_flags got=%b/%0d/%b exp=1/0/0", bus.MSEmpty, bus.MSDepth, bus.StackFault);
      end
   endtask

   task automatic test_push_pop();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, OP_PUSH, 1'b0, 1'b0, 1'b0);
         exp = sb.pop_front(); got = sample(); total++;
         if (got !== exp) begin bad++; $display("FAIL push%0d got=%h exp=%h", i, got, exp); end
      end
      total++;
      if (bus.MSTop !== 16'h0FFD || bus.MSDepth !== 3'd3) begin
         bad++; $display("FAIL push3_state got=%h/%0d exp=0ffd/3", bus.MSTop, bus.MSDepth);
      end
      drive(1'b1, OP_POP, 1'b0, 1'b0, 1'b0);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL pop1 got=%h exp=%h", got, exp); end
      total++;
      if (bus.MSTop !== 16'h0FFE || bus.MSNext !== 16'h0FFF || bus.MSDepth !== 3'd2) begin
         bad++; $display("FAIL pop1_state got=%h/%h/%0d exp=0ffe/0fff/2", bus.MSTop, bus.MSNext, bus.MSDepth);
      end
      // Idle cycle with pop direction asserted but no write enable.
      drive(1'b0, OP_POP, 1'b0, OP_POP, 1'b0);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL hold got=%h exp=%h", got, exp); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, OP_PUSH, 1'b0, 1'b0, 1'b0);
         exp = sb.pop_front(); got = sample(); total++;
         if (got !== exp) begin bad++; $display("FAIL fill%0d got=%h exp=%h", i, got, exp); end
      end
      total++;
      if (bus.MSTop !== 16'h0FFC || bus.MSFull !== 1'b1 || bus.MSOverflow !== 1'b1 || bus.StackFault !== 1'b1) begin
         bad++; $display("FAIL overflow_state got=%h/%b/%b/%b exp=0ffc/1/1/1",
                         bus.MSTop, bus.MSFull, bus.MSOverflow, bus.StackFault);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL errclr got=%h exp=%h", got, exp); end
      total++;
      if (bus.MSOverflow !== 1'b0 || bus.MSTop !== 16'h0FFC) begin
         bad++; $display("FAIL errclr_state got=%b/%h exp=0/0ffc", bus.MSOverflow, bus.MSTop);
      end
      drive(1'b1, OP_POP, 1'b0, 1'b0, 1'b0);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL pop_after_ovf got=%h exp=%h", got, exp); end
   endtask

   task automatic test_underflow();
      do_reset();
      drive(1'b0, 1'b0, 1'b1, OP_POP, 1'b0);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL rs_udf got=%h exp=%h", got, exp); end
      total++;
      if (bus.RSTop !== 16'h1800 || bus.RSUnderflow !== 1'b1) begin
         bad++; $display("FAIL rs_udf_state got=%h/%b exp=1800/1", bus.RSTop, bus.RSUnderflow);
      end
      drive(1'b0, 1'b0, 1'b1, OP_POP, 1'b1);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL udf_vs_clr got=%h exp=%h", got, exp); end
      total++;
      if (bus.RSUnderflow !== 1'b1) begin bad++; $display("FAIL udf_wins got=%b exp=1", bus.RSUnderflow); end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, OP_PUSH, (i == 0));
         exp = sb.pop_front(); got = sample(); total++;
         if (got !== exp) begin bad++; $display("FAIL rs_fill%0d got=%h exp=%h", i, got, exp); end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b1, OP_PUSH, 1'b1, OP_PUSH, 1'b0);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL dual_push got=%h exp=%h", got, exp); end
      total++;
      if (bus.MSTop !== 16'h0FFF || bus.RSTop !== 16'h17FF) begin
         bad++; $display("FAIL dual_push_ptr got=%h/%h exp=0fff/17ff", bus.MSTop, bus.RSTop);
      end
      drive(1'b1, OP_POP, 1'b1, OP_POP, 1'b0);
      exp = sb.pop_front(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL dual_pop got=%h exp=%h", got, exp); end
      total++;
      if (bus.MSTop !== 16'h1000 || bus.RSTop !== 16'h1800 || bus.StackFault !== 1'b0 || bus.RSEmpty !== 1'b1) begin
         bad++; $display("FAIL dual_pop_state got=%h/%h/%b/%b exp=1000/1800/0/1",
                         bus.MSTop, bus.RSTop, bus.StackFault, bus.RSEmpty);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, OP_PUSH, 1'b0, 1'b0, 1'b0);
         exp = sb.pop_front(); got = sample(); total++;
         if (got !== exp) begin bad++; $display("FAIL pre_rst%0d got=%h exp=%h", i, got, exp); end
      end
      #3;
      CtrlRst = 1'b1;
      model_reset();
      #1;
      exp = model_snap(); got = sample(); total++;
      if (got !== exp) begin bad++; $display("FAIL async_rst got=%h exp=%h", got, exp); end
      total++;
      if (bus.MSTop !== 16'h1000 || bus.MSDepth !== 3'd0 || bus.MSEmpty !== 1'b1) begin
         bad++; $display("FAIL async_rst_state got=%h/%0d/%b exp=1000/0/1", bus.MSTop, bus.MSDepth, bus.MSEmpty);
      end
      #2;
      CtrlRst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.MSPWrite = 1'b0; bus.MSPop = 1'b0;
      bus.RSPWrite = 1'b0; bus.RSPop = 1'b0;
      bus.ErrClr   = 1'b0;
      CtrlRst      = 1'b1;
      model_reset();
      #12;
      CtrlRst = 1'b0;
      test_reset();
      test_push_pop();
      test_overflow();
      test_underflow();
      test_back_to_back();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/stack_pointer_unit.md
Name: stack_pointer_unit

Overview:
Owns the main-stack pointer (MSP) and return-stack pointer (RSP) of the stack CPU and consumes the control unit's MSPop/MSPWrite/RSPop/RSPWrite strobes. Each cycle it presents top-of-stack, next-of-stack and push-target addresses to the memory stage. It tracks occupancy and flags overflow/underflow. Both stacks grow downward; each pointer addresses the current top element.

Parameters:
ADDR_W, 16, address width of all pointer outputs.
MS_BASE, 16'h1000, main-stack empty pointer value; first push writes MS_BASE-1.
MS_SIZE, 256, main-stack capacity in words.
RS_BASE, 16'h1800, return-stack empty pointer value.
RS_SIZE, 64, return-stack capacity in words.

Ports:
CLK  in  1  clock, all state updates on posedge.
CtrlRst  in  1  reset, asynchronous, active-high.
MSPWrite  in  1  main-stack pointer update enable.
MSPop  in  1  direction when MSPWrite=1: 1=pop, 0=push.
RSPWrite  in  1  return-stack pointer update enable.
RSPop  in  1  direction when RSPWrite=1: 1=pop, 0=push.
ErrClr  in  1  synchronous clear of sticky error flags.
MSTop  out  ADDR_W  address of main-stack top element (=MSP).
MSNext  out  ADDR_W  address of second element (=MSP+1).
MSPushAddr  out  ADDR_W  address the next push writes (=MSP-1).
RSTop  out  ADDR_W  address of return-stack top (=RSP).
RSPushAddr  out  ADDR_W  address the next return push writes (=RSP-1).
MSDepth  out  $clog2(MS_SIZE+1)  main-stack occupancy.
RSDepth  out  $clog2(RS_SIZE+1)  return-stack occupancy.
MSEmpty, MSFull, RSEmpty, RSFull  out  1 each  combinational from depth.
MSOverflow, MSUnderflow, RSOverflow, RSUnderflow  out  1 each  sticky fault flags.
StackFault  out  1  OR of the four sticky flags.

Behaviour:
- Reset (async, CtrlRst=1): MSP=MS_BASE, RSP=RS_BASE, depths=0, all sticky flags=0. Outputs derive from these immediately, so MSTop=MS_BASE, MSPushAddr=MS_BASE-1, MSEmpty=1, MSFull=0. The same applies to the RS outputs. Reset asserted mid-operation aborts any update that cycle.
- Address outputs are combinational from the pointer registers. Memory uses the current-cycle addresses, and the pointer change is visible the cycle after the strobe (latency 1).
- Push (xSPWrite=1, xSPop=0) when not full: SP<=SP-1, depth<=depth+1.
- Pop (xSPWrite=1, xSPop=1) when not empty: SP<=SP+1, depth<=depth-1.
- Push when full: SP and depth unchanged, xOverflow<=1. Pop when empty: unchanged, xUnderflow<=1.
- Only the offending op is suppressed; later legal ops proceed normally.
- xSPWrite=0: hold, and xSPop is ignored.
- MS and RS are fully independent, so simultaneous strobes on both stacks both take effect in the same cycle.
- ErrClr=1 clears all sticky flags. If a fault occurs in the same cycle as ErrClr, the fault wins and the flag is set.
- Pointer arithmetic is modulo 2^ADDR_W. Base/size choices that wrap are a configuration error; no runtime check.
- Depth is kept as an explicit counter and is not derived from SP subtraction. Invariant: SP == BASE - depth.

Decomposition:
- Shared package: stack-op encoding constants (OP_PUSH=0, OP_POP=1) and the default base/size constants, which are also used by the memory map.
- One sub-module, stack_ptr. It is a single parameterised pointer + depth + sticky-flag engine (BASE, SIZE) and is instantiated twice (MS, RS).
- The top level only wires the instances and ORs StackFault.

Test Plan:
(Bench overrides MS_SIZE=4, RS_SIZE=2; bases at defaults.)
- Reset → MSTop=16'h1000, MSPushAddr=16'h0FFF, MSNext=16'h1001, RSTop=16'h1800, MSEmpty=1, MSDepth=0, StackFault=0.
- 3 MS pushes → MSTop=16'h0FFD, MSDepth=3. Then 1 pop → MSTop=16'h0FFE, MSNext=16'h0FFF, MSDepth=2.
- 4 MS pushes, then a 5th → MSTop stays 16'h0FFC, MSFull=1, MSOverflow=1, StackFault=1. Then ErrClr → MSOverflow=0, pointer still 16'h0FFC.
- RS pop from reset → RSTop stays 16'h1800, RSUnderflow=1. A pop fault in the same cycle as ErrClr → flag remains 1.
- Same cycle: MS push + RS push, then MS pop + RS pop → both pointers move together; the final state matches reset values with no flags set.
- Assert CtrlRst asynchronously mid-cycle with MSDepth=2 → outputs return to reset values before the next CLK edge.
